pad_row_ctrl: RTL
=================

Name: pad_row_ctrl

Overview:
- Sequencer for the zero-padding row-buffer datapath.
- Streams an IMG_W x IMG_H single-channel-timed pixel stream (R/G/B travel together) into three circular row slots of padded width IMG_W+2.
- Inserts the zero border: columns 0 and IMG_W+1, one zero row on top, one zero row on bottom.
- Presents one 3-row window per output row to the downstream conv engine under a valid/ack handshake.

Parameters:
IMG_W, 416, input image width in pixels (>=2)
IMG_H, 416, input image height in rows (>=2)
COL_W, 9, width of column address; must hold IMG_W+1
ROW_W, 9, width of row index; must hold IMG_H-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle frame start request; ignored while busy
img_valid  in  1  source pixel valid (imgDataValid)
img_ready  out  1  controller accepts a pixel this cycle
win_ack  in  1  consumer finished with current window
wr_en  out  1  write strobe to row-buffer datapath
wr_slot  out  2  target slot 0..2
wr_col  out  COL_W  padded column address 0..IMG_W+1
zero_fill  out  1  write data must be zero (border/pad row)
win_valid  out  1  window slots stable and ready
win_top  out  2  slot holding padded row k
win_mid  out  2  slot holding padded row k+1
win_bot  out  2  slot holding padded row k+2
out_row  out  ROW_W  output row index k of current window
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last window acked

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; win_top/mid/bot = 0/1/2.
- All outputs registered.
- Padded-row mapping: padded row p = input row p-1 for 1<=p<=IMG_H; p=0 and p=IMG_H+1 are zero rows. Window k (0..IMG_H-1) = padded rows k, k+1, k+2.
- States:
  - IDLE: on start -> CLR targeting slot 0; busy=1.
  - CLR: IMG_W+2 cycles, one column per cycle. wr_en=1, zero_fill=1, wr_col 0..IMG_W+1, img_ready=0. At col IMG_W+1 -> LOAD (prologue) or WIN (bottom pad).
  - LOAD:
    - Col 0: zero write, img_ready=0, one cycle.
    - Cols 1..IMG_W: img_ready=1; wr_en = img_valid; zero_fill=0; wr_col advances only on img_valid. Stalls hold state indefinitely.
    - Col IMG_W+1: zero write, img_ready=0.
    - After col IMG_W+1 -> next LOAD (prologue) or WIN.
  - Prologue: CLR slot0, LOAD input row0 into slot1, LOAD input row1 into slot2, then WIN with top/mid/bot=0/1/2, out_row=0.
  - WIN: win_valid=1 (level) until win_ack sampled high; win_ack ignored outside WIN. On ack:
    - If k==IMG_H-1 -> DONE.
    - Else rotate: top<=mid, mid<=bot, bot<=old top, out_row<=k+1; refill old top slot.
    - Refill with LOAD of input row k+2 if k+2 <= IMG_H-1, otherwise CLR (k+3 == IMG_H+1).
    - win_valid drops the cycle after the ack.
  - DONE: frame_done=1 for one cycle, busy<=0 -> IDLE.
- Latency: with img_valid held high, first win_valid rises 3*(IMG_W+2)+1 cycles after the start edge. Each later window rises IMG_W+3 cycles after its ack.
- Simultaneous events:
  - start during busy: ignored.
  - img_valid while img_ready=0: not consumed; the source holds the pixel.
  - win_ack coincident with reset: reset wins.
- Reset mid-operation: immediate return to IDLE; partial slot contents are don't-care; a new start reloads the whole frame.
- Counters: wr_col wraps to 0 at the end of every row; out_row never exceeds IMG_H-1; no arithmetic overflow for legal parameters.

Decomposition:
- Package pad_ctrl_pkg:
  - State encoding (IDLE, CLR, LOAD, WIN, DONE).
  - LOAD sub-phase encoding (LEFT, BODY, RIGHT).
  - Slot index typedef (2 bits).
  - Default IMG_W/IMG_H constants.
- Sub-module pad_slot_rotator: holds top/mid/bot, rotates on pulse, resets to 0/1/2, and exposes the refill target (current top).

Test Plan:
- W=4,H=3, img_valid always 1, start -> CLR slot0 cols 0..5 zero_fill; LOAD slot1 (col0 zero, cols1..4 pixels, col5 zero); LOAD slot2; win_valid at cycle 19 with top/mid/bot=0/1/2, out_row=0.
- Same frame, ack window 0 -> LOAD input row2 into slot0; win top/mid/bot=1/2/0, out_row=1. Ack -> CLR slot1 (6 zero writes); win 2/0/1, out_row=2. Ack -> frame_done pulse one cycle later, busy=0.
- img_valid toggled 1,0,1,0 during BODY -> wr_col increments only on valid cycles; 4 pixels written to cols 1..4; no extra writes.
- win_ack held low 50 cycles -> win_valid stays high, no wr_en; second start pulse meanwhile -> no effect.
- reset asserted mid-LOAD of row1 -> all outputs 0 immediately; new start -> complete correct frame from CLR slot0.
- IMG_W=416, IMG_H=416 full frame with random valid gaps -> exactly 416 windows, out_row 0..415, 418*418 total wr_en pulses.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// Shared encodings and constants for the zero-padding row-buffer sequencer.
// Slot indices are always 0..2; the three row slots are used as a circular buffer.
package pad_ctrl_pkg;

    localparam int DEFAULT_IMG_W = 416;
    localparam int DEFAULT_IMG_H = 416;

    // Top-level sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_WIN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Column phases inside one LOAD row
    localparam logic [1:0] PH_LEFT  = 2'd0;
    localparam logic [1:0] PH_BODY  = 2'd1;
    localparam logic [1:0] PH_RIGHT = 2'd2;

    typedef logic [1:0] slot_t;

    // Next slot in the 0 -> 1 -> 2 -> 0 ring.
    function automatic slot_t slot_inc(input slot_t s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/pad_slot_rotator.sv
// Tracks which physical slot holds the top, middle and bottom row of the window.
// The slot that is about to drop out of the window (current top) is the refill target.
module pad_slot_rotator
    import pad_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  rotate,
    output slot_t top,
    output slot_t mid,
    output slot_t bot,
    output slot_t refill
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top <= 2'd0;
            mid <= 2'd1;
            bot <= 2'd2;
        end else if (clear) begin
            top <= 2'd0;
            mid <= 2'd1;
            bot <= 2'd2;
        end else if (rotate) begin
            // NOTE: non-blocking assignments make this a true three-way swap on old values.
            top <= mid;
            mid <= bot;
            bot <= top;
        end
    end

    assign refill = top;

endmodule

// File: rtl/pad_row_ctrl.sv
// Sequencer that streams an image into three circular padded row slots and
// presents one 3-row window per output row to the conv engine.
module pad_row_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int IMG_W = DEFAULT_IMG_W,
    parameter int IMG_H = DEFAULT_IMG_H,
    parameter int COL_W = 9,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             img_valid,
    output logic             img_ready,
    input  logic             win_ack,
    output logic             wr_en,
    output logic [1:0]       wr_slot,
    output logic [COL_W-1:0] wr_col,
    output logic             zero_fill,
    output logic             win_valid,
    output logic [1:0]       win_top,
    output logic [1:0]       win_mid,
    output logic [1:0]       win_bot,
    output logic [ROW_W-1:0] out_row,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W);
    localparam logic [COL_W-1:0] COL_RIGHT = COL_W'(IMG_W + 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_PEN   = ROW_W'(IMG_H - 2);

    logic [2:0]       state;
    logic [1:0]       phase;
    logic [COL_W-1:0] col;
    logic [1:0]       pro_cnt;
    slot_t            tgt;

    logic  win_taken;
    logic  rot_clear;
    logic  rot_pulse;
    slot_t rot_top;
    slot_t rot_mid;
    slot_t rot_bot;
    slot_t rot_refill;

    assign win_taken = (state == ST_WIN) && win_valid && win_ack;
    assign rot_clear = (state == ST_IDLE) && start;
    assign rot_pulse = win_taken && (out_row != ROW_LAST);

    pad_slot_rotator u_rot (
        .clk    (clk),
        .reset  (reset),
        .clear  (rot_clear),
        .rotate (rot_pulse),
        .top    (rot_top),
        .mid    (rot_mid),
        .bot    (rot_bot),
        .refill (rot_refill)
    );

    assign win_top = rot_top;
    assign win_mid = rot_mid;
    assign win_bot = rot_bot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            phase      <= PH_LEFT;
            col        <= '0;
            pro_cnt    <= '0;
            tgt        <= '0;
            img_ready  <= 1'b0;
            wr_en      <= 1'b0;
            wr_slot    <= '0;
            wr_col     <= '0;
            zero_fill  <= 1'b0;
            win_valid  <= 1'b0;
            out_row    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            zero_fill  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    wr_col <= '0;
                    if (start) begin
                        state   <= ST_CLR;
                        busy    <= 1'b1;
                        col     <= '0;
                        pro_cnt <= '0;
                        tgt     <= '0;
                        out_row <= '0;
                    end
                end

                ST_CLR: begin
                    wr_en     <= 1'b1;
                    zero_fill <= 1'b1;
                    wr_slot   <= tgt;
                    wr_col    <= col;
                    if (col == COL_RIGHT) begin
                        col <= '0;
                        if (pro_cnt != 2'd2) begin
                            pro_cnt <= pro_cnt + 2'd1;
                            tgt     <= slot_inc(tgt);
                            state   <= ST_LOAD;
                            phase   <= PH_LEFT;
                        end else begin
                            state <= ST_WIN;
                        end
                    end else begin
                        col <= col + COL_FIRST;
                    end
                end

                ST_LOAD: begin
                    case (phase)
                        PH_LEFT: begin
                            wr_en     <= 1'b1;
                            zero_fill <= 1'b1;
                            wr_slot   <= tgt;
                            wr_col    <= '0;
                            col       <= COL_FIRST;
                            phase     <= PH_BODY;
                            img_ready <= 1'b1;
                        end
                        PH_BODY: begin
                            // A pixel is consumed only when the source offers it; otherwise hold.
                            if (img_valid) begin
                                wr_en   <= 1'b1;
                                wr_slot <= tgt;
                                wr_col  <= col;
                                col     <= col + COL_FIRST;
                                if (col == COL_LAST) begin
                                    img_ready <= 1'b0;
                                    phase     <= PH_RIGHT;
                                end
                            end
                        end
                        default: begin
                            wr_en     <= 1'b1;
                            zero_fill <= 1'b1;
                            wr_slot   <= tgt;
                            wr_col    <= COL_RIGHT;
                            col       <= '0;
                            phase     <= PH_LEFT;
                            if (pro_cnt != 2'd2) begin
                                pro_cnt <= pro_cnt + 2'd1;
                                tgt     <= slot_inc(tgt);
                            end else begin
                                state <= ST_WIN;
                            end
                        end
                    endcase
                end

                ST_WIN: begin
                    wr_col <= '0;
                    // win_valid rises one cycle after entry so the last row write has landed.
                    if (win_taken) begin
                        win_valid <= 1'b0;
                        if (out_row == ROW_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            out_row <= out_row + ROW_W'(1);
                            tgt     <= rot_refill;
                            col     <= '0;
                            if (out_row == ROW_PEN) begin
                                state <= ST_CLR;
                            end else begin
                                state <= ST_LOAD;
                                phase <= PH_LEFT;
                            end
                        end
                    end else begin
                        win_valid <= 1'b1;
                    end
                end

                ST_DONE: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
